// File: rtl/data_ram_arb_pkg.sv
// Shared size codes, FSM state type and counter width for the data_ram arbiter.
package data_ram_arb_pkg;

    localparam logic [1:0] WBE_NONE = 2'b00;
    localparam logic [1:0] WBE_BYTE = 2'b01;
    localparam logic [1:0] WBE_HALF = 2'b10;
    localparam logic [1:0] WBE_WORD = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_PEND,
        ARB_RESP
    } arb_state_t;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/data_ram_arbiter_if.sv
// Debug/loader master req/gnt handshake bundle for the data_ram arbiter.
interface data_ram_arb_dbg_if #(
    parameter int ADDR_W = 32
);
    logic              dbg_req;
    logic              dbg_we;
    logic [1:0]        dbg_size;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [31:0]       dbg_rdata;

    modport master (
        output dbg_req, dbg_we, dbg_size, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata
    );

    modport slave (
        input  dbg_req, dbg_we, dbg_size, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata
    );
endinterface

// File: rtl/data_ram_arb_mux.sv
// Combinational CPU/debug select onto the single data_ram port.
module data_ram_arb_mux
    import data_ram_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              sel_dbg_i,
    input  logic              force_idle_i,
    input  logic              cpu_stall_i,
    input  logic [1:0]        cpu_write_byte_en_i,
    input  logic [ADDR_W-1:0] cpu_raddr_i,
    input  logic [ADDR_W-1:0] cpu_waddr_i,
    input  logic [31:0]       cpu_wdata_i,
    input  logic              dbg_we_i,
    input  logic [1:0]        dbg_size_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [31:0]       dbg_wdata_i,
    output logic [1:0]        ram_write_byte_en_o,
    output logic [ADDR_W-1:0] ram_raddr_o,
    output logic [ADDR_W-1:0] ram_waddr_o,
    output logic [31:0]       ram_wdata_o
);

    always_comb begin
        ram_write_byte_en_o = cpu_write_byte_en_i;
        ram_raddr_o         = cpu_raddr_i;
        ram_waddr_o         = cpu_waddr_i;
        ram_wdata_o         = cpu_wdata_i;
        if (sel_dbg_i) begin
            ram_raddr_o         = dbg_addr_i;
            ram_waddr_o         = dbg_addr_i;
            ram_wdata_o         = dbg_wdata_i;
            ram_write_byte_en_o = dbg_we_i ? dbg_size_i : WBE_NONE;
        end else if (cpu_stall_i) begin
            ram_write_byte_en_o = WBE_NONE;
        end
        // Reset must never let a stray store reach the RAM.
        if (force_idle_i) begin
            ram_write_byte_en_o = WBE_NONE;
        end
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares data_ram between the CPU load/store path (priority) and a debug/loader master.
// Optional statistics counters are built when DATA_RAM_ARB_STATS_EN is defined.
module data_ram_arbiter
    import data_ram_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_mem_active,
    input  logic [1:0]             cpu_write_byte_en,
    input  logic [ADDR_W-1:0]      cpu_raddr,
    input  logic [ADDR_W-1:0]      cpu_waddr,
    input  logic [31:0]            cpu_wdata,
    output logic [31:0]            cpu_rdata,
    output logic                   cpu_stall,
    data_ram_arb_dbg_if.slave      dbg,
    output logic [1:0]             ram_write_byte_en,
    output logic [ADDR_W-1:0]      ram_raddr,
    output logic [ADDR_W-1:0]      ram_waddr,
    output logic [31:0]            ram_wdata,
    input  logic [31:0]            ram_rdata,
    output logic [31:0]            stat_dbg_grants,
    output logic [31:0]            stat_forced_stalls
);

    arb_state_t          state_q, state_d;
    logic [STARVE_W-1:0] cnt_q, cnt_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                gnt;
    logic                stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        gnt     = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (dbg.dbg_req) begin
                    if (!cpu_mem_active) begin
                        gnt = 1'b1;
                    end else begin
                        state_d = ARB_PEND;
                        cnt_d   = STARVE_W'(1);
                    end
                end
            end
            ARB_PEND: begin
                if (!cpu_mem_active) begin
                    gnt = 1'b1;
                end else if (cnt_q == STARVE_W'(STARVE_LIMIT)) begin
                    gnt   = 1'b1;
                    stall = 1'b1;
                end else begin
                    cnt_d = cnt_q + STARVE_W'(1);
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
        if (gnt) begin
            state_d = dbg.dbg_we ? ARB_IDLE : ARB_RESP;
            cnt_d   = '0;
            if (!dbg.dbg_we) begin
                rdata_d = ram_rdata;
            end
        end
        if (rst) begin
            gnt   = 1'b0;
            stall = 1'b0;
        end
    end

    assign dbg.dbg_gnt    = gnt;
    assign dbg.dbg_rvalid = (state_q == ARB_RESP) && !rst;
    assign dbg.dbg_rdata  = rdata_q;
    assign cpu_stall      = stall;
    assign cpu_rdata      = ram_rdata;

    data_ram_arb_mux #(
        .ADDR_W (ADDR_W)
    ) u_mux (
        .sel_dbg_i           (gnt),
        .force_idle_i        (rst),
        .cpu_stall_i         (stall),
        .cpu_write_byte_en_i (cpu_write_byte_en),
        .cpu_raddr_i         (cpu_raddr),
        .cpu_waddr_i         (cpu_waddr),
        .cpu_wdata_i         (cpu_wdata),
        .dbg_we_i            (dbg.dbg_we),
        .dbg_size_i          (dbg.dbg_size),
        .dbg_addr_i          (dbg.dbg_addr),
        .dbg_wdata_i         (dbg.dbg_wdata),
        .ram_write_byte_en_o (ram_write_byte_en),
        .ram_raddr_o         (ram_raddr),
        .ram_waddr_o         (ram_waddr),
        .ram_wdata_o         (ram_wdata)
    );

`ifdef DATA_RAM_ARB_STATS_EN
    logic [31:0] stat_grants_q, stat_stalls_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants_q <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (gnt) stat_grants_q <= stat_grants_q + 32'd1;
            if (stall) stat_stalls_q <= stat_stalls_q + 32'd1;
        end
    end

    assign stat_dbg_grants    = stat_grants_q;
    assign stat_forced_stalls = stat_stalls_q;
`else
    assign stat_dbg_grants    = '0;
    assign stat_forced_stalls = '0;
`endif

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Scoreboard bench for data_ram_arbiter with a byte-addressed behavioural data_ram.
module tb_data_ram_arbiter;
    import data_ram_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        cpu_mem_active;
    logic [1:0]  cpu_write_byte_en;
    logic [31:0] cpu_raddr, cpu_waddr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic [1:0]  ram_write_byte_en;
    logic [31:0] ram_raddr, ram_waddr, ram_wdata, ram_rdata;
    logic [31:0] stat_dbg_grants, stat_forced_stalls;

    data_ram_arb_dbg_if #(.ADDR_W(32)) dif ();

    data_ram_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .cpu_mem_active     (cpu_mem_active),
        .cpu_write_byte_en  (cpu_write_byte_en),
        .cpu_raddr          (cpu_raddr),
        .cpu_waddr          (cpu_waddr),
        .cpu_wdata          (cpu_wdata),
        .cpu_rdata          (cpu_rdata),
        .cpu_stall          (cpu_stall),
        .dbg                (dif.slave),
        .ram_write_byte_en  (ram_write_byte_en),
        .ram_raddr          (ram_raddr),
        .ram_waddr          (ram_waddr),
        .ram_wdata          (ram_wdata),
        .ram_rdata          (ram_rdata),
        .stat_dbg_grants    (stat_dbg_grants),
        .stat_forced_stalls (stat_forced_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data_ram: combinational read, little-endian byte lanes from wdata[7:0] upward.
    logic [7:0] mem [0:255];
    logic [7:0] ra, wa;
    assign ra = ram_raddr[7:0];
    assign wa = ram_waddr[7:0];
    always_comb ram_rdata = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};

    always @(posedge clk) begin
        case (ram_write_byte_en)
            WBE_BYTE: mem[wa] <= ram_wdata[7:0];
            WBE_HALF: begin
                mem[wa]        <= ram_wdata[7:0];
                mem[wa + 8'd1] <= ram_wdata[15:8];
            end
            WBE_WORD: begin
                mem[wa]        <= ram_wdata[7:0];
                mem[wa + 8'd1] <= ram_wdata[15:8];
                mem[wa + 8'd2] <= ram_wdata[23:16];
                mem[wa + 8'd3] <= ram_wdata[31:24];
            end
            default: ;
        endcase
    end

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Read-response monitor: rvalid exactly one cycle after a read grant, data from the scoreboard.
    logic prev_rd_gnt, prev_stall;
    initial begin
        prev_rd_gnt = 1'b0;
        prev_stall  = 1'b0;
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_rd_gnt <= 1'b0;
            prev_stall  <= 1'b0;
        end else begin
            chk("rvalid_latency", 32'(dif.dbg_rvalid), 32'(prev_rd_gnt));
            if (dif.dbg_rvalid) begin
                chk("rd_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("dbg_rdata", dif.dbg_rdata, exp_q.pop_front());
            end
            if (prev_stall) chk("stall_consecutive", 32'(cpu_stall), 32'd0);
            prev_rd_gnt <= dif.dbg_gnt && !dif.dbg_we;
            prev_stall  <= cpu_stall;
        end
    end

    logic [1:0]  cpu_wbe_cfg;
    logic [31:0] cpu_wbase, cpu_winc;

    // Issue one debug transaction; the CPU is busy for the first 'busy' cycles of the wait.
    task automatic run_dbg(input string tag, input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata, input int busy,
                           input int exp_wait, input logic exp_stall, input logic [31:0] exp_rd);
        int k;
        bit done;
        dif.dbg_req   = 1'b1;
        dif.dbg_we    = we;
        dif.dbg_size  = size;
        dif.dbg_addr  = addr;
        dif.dbg_wdata = wdata;
        k = 0;
        done = 1'b0;
        while (!done && k < 20) begin
            cpu_mem_active    = (k < busy);
            cpu_write_byte_en = (k < busy) ? cpu_wbe_cfg : WBE_NONE;
            cpu_wdata         = cpu_wbase + 32'(k) * cpu_winc;
            @(negedge clk);
            if (dif.dbg_gnt) begin
                done = 1'b1;
                chk({tag, "_wait"}, 32'(k), 32'(exp_wait));
                chk({tag, "_stall"}, 32'(cpu_stall), 32'(exp_stall));
                chk({tag, "_wbe"}, 32'(ram_write_byte_en), 32'(we ? size : WBE_NONE));
                chk({tag, "_addr"}, ram_raddr, addr);
                if (we) chk({tag, "_wdata"}, ram_wdata, wdata);
                else exp_q.push_back(exp_rd);
            end else begin
                chk({tag, "_nostall"}, 32'(cpu_stall), 32'd0);
            end
            @(posedge clk);
            #1;
            k++;
        end
        if (!done) chk({tag, "_timeout"}, 32'(k), 32'(exp_wait));
        dif.dbg_req       = 1'b0;
        cpu_mem_active    = 1'b0;
        cpu_write_byte_en = WBE_NONE;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst               = 1'b1;
        cpu_mem_active    = 1'b1;
        cpu_write_byte_en = WBE_WORD;
        cpu_raddr         = 32'h0;
        cpu_waddr         = 32'hF0;
        cpu_wdata         = 32'h12345678;
        cpu_wbe_cfg       = WBE_NONE;
        cpu_wbase         = 32'h0;
        cpu_winc          = 32'h0;
        dif.dbg_req       = 1'b1;
        dif.dbg_we        = 1'b0;
        dif.dbg_size      = WBE_NONE;
        dif.dbg_addr      = 32'h0;
        dif.dbg_wdata     = 32'h0;

        // Reset state, with a pending request and CPU store both present.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(dif.dbg_gnt), 32'd0);
        chk("rst_rvalid", 32'(dif.dbg_rvalid), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_rdata", dif.dbg_rdata, 32'd0);
        chk("rst_wbe", 32'(ram_write_byte_en), 32'(WBE_NONE));
        chk("rst_stat_gnt", stat_dbg_grants, 32'd0);
        chk("rst_stat_stall", stat_forced_stalls, 32'd0);
        @(posedge clk);
        #1;
        rst               = 1'b0;
        dif.dbg_req       = 1'b0;
        cpu_mem_active    = 1'b0;
        cpu_write_byte_en = WBE_NONE;
        @(posedge clk);
        #1;

        run_dbg("preload_wr", 1'b1, WBE_WORD, 32'h40, 32'hDEADBEEF, 0, 0, 1'b0, 32'h0);
        run_dbg("preload_rd", 1'b0, WBE_NONE, 32'h40, 32'h0, 0, 0, 1'b0, 32'hDEADBEEF);

        // Starvation: CPU stores 0x100+k to 0xC0 each busy cycle; the stalled store must be dropped.
        cpu_waddr = 32'hC0; cpu_wbe_cfg = WBE_WORD; cpu_wbase = 32'h100; cpu_winc = 32'h1;
        run_dbg("starve_rd", 1'b0, WBE_NONE, 32'h40, 32'h0, 99, 4, 1'b1, 32'hDEADBEEF);
        cpu_wbe_cfg = WBE_NONE;
        run_dbg("starve_mem", 1'b0, WBE_NONE, 32'hC0, 32'h0, 0, 0, 1'b0, 32'h00000103);

        run_dbg("idle_gap", 1'b0, WBE_NONE, 32'h40, 32'h0, 2, 2, 1'b0, 32'hDEADBEEF);

        // Collision: CPU stores 0x1 to 0x80 while a debug write of 0x2 is force-granted.
        cpu_waddr = 32'h80; cpu_wbe_cfg = WBE_WORD; cpu_wbase = 32'h1; cpu_winc = 32'h0;
        run_dbg("collide_wr", 1'b1, WBE_WORD, 32'h80, 32'h2, 99, 4, 1'b1, 32'h0);
        cpu_wbe_cfg = WBE_NONE;
        run_dbg("collide_rd", 1'b0, WBE_NONE, 32'h80, 32'h0, 0, 0, 1'b0, 32'h2);

        run_dbg("byte_wr", 1'b1, WBE_BYTE, 32'h41, 32'h000000AA, 1, 1, 1'b0, 32'h0);
        run_dbg("byte_rd", 1'b0, WBE_NONE, 32'h40, 32'h0, 0, 0, 1'b0, 32'hDEADAAEF);

        // Reset asserted in the RESP cycle drops the response.
        dif.dbg_req = 1'b1; dif.dbg_we = 1'b0; dif.dbg_addr = 32'h40;
        @(negedge clk);
        chk("rresp_gnt", 32'(dif.dbg_gnt), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1; dif.dbg_req = 1'b0;
        cpu_mem_active = 1'b1; cpu_write_byte_en = WBE_WORD; cpu_waddr = 32'hF0;
        @(negedge clk);
        chk("rresp_rvalid", 32'(dif.dbg_rvalid), 32'd0);
        chk("rresp_wbe", 32'(ram_write_byte_en), 32'(WBE_NONE));
        @(posedge clk);
        #1;
        chk("rresp_state", 32'(dut.state_q), 32'(ARB_IDLE));
        rst = 1'b0; cpu_mem_active = 1'b0; cpu_write_byte_en = WBE_NONE;
        @(negedge clk);
        chk("rresp_no_rvalid", 32'(dif.dbg_rvalid), 32'd0);
        @(posedge clk);
        #1;

        // Statistics: three grants, one of them forced.
        run_dbg("stat_wr", 1'b1, WBE_WORD, 32'h10, 32'h7, 0, 0, 1'b0, 32'h0);
        run_dbg("stat_rd", 1'b0, WBE_NONE, 32'h10, 32'h0, 0, 0, 1'b0, 32'h7);
        run_dbg("stat_forced", 1'b0, WBE_NONE, 32'h10, 32'h0, 99, 4, 1'b1, 32'h7);
        @(negedge clk);
`ifdef DATA_RAM_ARB_STATS_EN
        chk("stat_dbg_grants", stat_dbg_grants, 32'd3);
        chk("stat_forced_stalls", stat_forced_stalls, 32'd1);
`else
        chk("stat_dbg_grants", stat_dbg_grants, 32'd0);
        chk("stat_forced_stalls", stat_forced_stalls, 32'd0);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rd_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
